// File: rtl/mic_dma_pkg.sv
// Shared types and constants for the microphone ring DMA.
package mic_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_FRAME,
        SELECT,
        SETTLE,
        WRITE,
        FIN
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_CH         = 8;

endpackage

// File: rtl/mic_dma_addr_gen.sv
// Write address generator: channel base accumulates the stride, sample offset
// accumulates one word per frame, so no multiplier is needed.
module mic_dma_addr_gen
    import mic_dma_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load_i,
    input  logic [31:0] base_i,
    input  logic [31:0] stride_i,
    input  logic        ch_adv_i,
    input  logic        frame_adv_i,
    input  logic        wrap_i,
    output logic [31:0] addr_o
);

    logic [31:0] base_q,    base_d;
    logic [31:0] stride_q,  stride_d;
    logic [31:0] ch_base_q, ch_base_d;
    logic [31:0] idx_off_q, idx_off_d;

    always_comb begin
        base_d    = base_q;
        stride_d  = stride_q;
        ch_base_d = ch_base_q;
        idx_off_d = idx_off_q;
        if (load_i) begin
            base_d    = base_i;
            stride_d  = stride_i;
            ch_base_d = base_i;
            idx_off_d = '0;
        end else if (ch_adv_i) begin
            ch_base_d = ch_base_q + stride_q;
        end else if (frame_adv_i) begin
            ch_base_d = base_q;
            idx_off_d = idx_off_q + 32'(BYTES_PER_WORD);
        end else if (wrap_i) begin
            ch_base_d = base_q;
            idx_off_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_q    <= '0;
            stride_q  <= '0;
            ch_base_q <= '0;
            idx_off_q <= '0;
        end else begin
            base_q    <= base_d;
            stride_q  <= stride_d;
            ch_base_q <= ch_base_d;
            idx_off_q <= idx_off_d;
        end
    end

    // Modulo-2^32 wrap is the natural behaviour of the 32-bit add.
    assign addr_o = ch_base_q + idx_off_q;

endmodule

// File: rtl/mic_dma_ring.sv
// Multi-channel microphone sampler that writes each frame's channels into
// per-channel ring regions over an Avalon-MM write master.
//
// state      | meaning
// IDLE       | waiting for start
// ARM        | latch configuration, clear index and overrun
// WAIT_FRAME | waiting for sample_valid
// SELECT     | drive select for the current channel
// SETTLE     | wait for the mux to settle, then capture mic_data
// WRITE      | Avalon write pending until accepted
// FIN        | linear run complete, waiting for start to drop
module mic_dma_ring
    import mic_dma_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int SEL_W   = 3,
    parameter int SEL_LAT = 2,
    parameter int CNT_W   = 24
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [31:0]       AM_ADDR,
    output logic [2:0]        AM_BURSTCOUNT,
    output logic              AM_WRITE,
    output logic [31:0]       AM_WRITEDATA,
    output logic [3:0]        AM_BYTEENABLE,
    input  logic              AM_WAITREQUEST,
    input  logic [31:0]       mic_data,
    output logic [SEL_W-1:0]  select,
    input  logic              sample_valid,
    input  logic              start,
    input  logic              circular,
    input  logic [31:0]       start_address,
    input  logic [31:0]       ch_stride,
    input  logic [CNT_W-1:0]  number_samples,
    input  logic              half_way_ack,
    input  logic              end_ack,
    output logic              half_way_latch,
    output logic              end_latch,
    output logic              overrun,
    output logic              FINISHED,
    output logic              busy
);

    localparam int                CH_LIMIT    = (NUM_CH > MAX_CH) ? MAX_CH : NUM_CH;
    localparam logic [SEL_W-1:0]  LAST_CH     = SEL_W'(CH_LIMIT - 1);
    localparam logic [2:0]        SETTLE_INIT = 3'(SEL_LAT - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0]  idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0]  n_q, n_d;
    logic              circ_q, circ_d;
    logic [2:0]        settle_q, settle_d;
    logic [31:0]       data_q, data_d;
    logic              hw_q, hw_d, end_q, end_d, ovr_q, ovr_d;
    logic              hw_set, end_set, accept;
    logic              ag_load, ag_ch, ag_frame, ag_wrap;

    assign accept  = (state_q == WRITE) && !AM_WAITREQUEST;
    assign idx_inc = idx_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        idx_d    = idx_q;
        n_d      = n_q;
        circ_d   = circ_q;
        settle_d = settle_q;
        data_d   = data_q;
        hw_set   = 1'b0;
        end_set  = 1'b0;
        ag_load  = 1'b0;
        ag_ch    = 1'b0;
        ag_frame = 1'b0;
        ag_wrap  = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = ARM;
            ARM: begin
                n_d     = number_samples;
                circ_d  = circular;
                idx_d   = '0;
                ch_d    = '0;
                ag_load = 1'b1;
                if (!start) state_d = IDLE;
                else if (number_samples == '0) begin
                    end_set = 1'b1;
                    state_d = FIN;
                end else state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!start) state_d = IDLE;
                else if (sample_valid) begin
                    ch_d    = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                settle_d = SETTLE_INIT;
                state_d  = start ? SETTLE : IDLE;
            end
            SETTLE: begin
                if (!start) state_d = IDLE;
                else if (settle_q == '0) begin
                    data_d  = mic_data;
                    state_d = WRITE;
                end else settle_d = settle_q - 3'd1;
            end
            WRITE: begin
                // An abort still lets the pending write finish before leaving.
                if (accept) begin
                    if (ch_q != LAST_CH) begin
                        ch_d    = ch_q + SEL_W'(1);
                        ag_ch   = 1'b1;
                        state_d = start ? SELECT : IDLE;
                    end else begin
                        ch_d   = '0;
                        hw_set = (idx_inc == (n_q >> 1));
                        if (idx_inc == n_q) begin
                            end_set = 1'b1;
                            if (circ_q) begin
                                idx_d   = '0;
                                ag_wrap = 1'b1;
                                state_d = start ? WAIT_FRAME : IDLE;
                            end else begin
                                idx_d   = idx_inc;
                                state_d = start ? FIN : IDLE;
                            end
                        end else begin
                            idx_d    = idx_inc;
                            ag_frame = 1'b1;
                            state_d  = start ? WAIT_FRAME : IDLE;
                        end
                    end
                end
            end
            FIN: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == ARM) ovr_d = 1'b0;
        else if (sample_valid && state_q != WAIT_FRAME) ovr_d = 1'b1;
        else ovr_d = ovr_q;

        // An ack coinciding with a set condition suppresses that set.
        hw_d  = half_way_ack ? 1'b0 : (hw_set  ? 1'b1 : hw_q);
        end_d = end_ack      ? 1'b0 : (end_set ? 1'b1 : end_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            circ_q   <= 1'b0;
            settle_q <= '0;
            data_q   <= '0;
            hw_q     <= 1'b0;
            end_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            circ_q   <= circ_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            hw_q     <= hw_d;
            end_q    <= end_d;
            ovr_q    <= ovr_d;
        end
    end

    mic_dma_addr_gen u_addr_gen (
        .CLK         (CLK),
        .RESET       (RESET),
        .load_i      (ag_load),
        .base_i      (start_address),
        .stride_i    (ch_stride),
        .ch_adv_i    (ag_ch),
        .frame_adv_i (ag_frame),
        .wrap_i      (ag_wrap),
        .addr_o      (AM_ADDR)
    );

    assign AM_WRITE       = (state_q == WRITE);
    assign AM_WRITEDATA   = data_q;
    assign AM_BURSTCOUNT  = 3'd1;
    assign AM_BYTEENABLE  = 4'hF;
    assign select         = ch_q;
    assign half_way_latch = hw_q;
    assign end_latch      = end_q;
    assign overrun        = ovr_q;
    assign FINISHED       = (state_q == FIN);
    assign busy           = (state_q != IDLE) && (state_q != FIN);

endmodule

// File: tb/tb_mic_dma_ring.sv
// Scoreboard bench for mic_dma_ring: each accepted frame queues its expected
// writes, and a negedge monitor pops and compares every write the DUT issues.
module tb_mic_dma_ring;

    localparam int NUM_CH  = 5;
    localparam int SEL_W   = 3;
    localparam int SEL_LAT = 2;
    localparam int CNT_W   = 24;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [31:0]       AM_ADDR;
    logic [2:0]        AM_BURSTCOUNT;
    logic              AM_WRITE;
    logic [31:0]       AM_WRITEDATA;
    logic [3:0]        AM_BYTEENABLE;
    logic              AM_WAITREQUEST = 1'b0;
    logic [31:0]       mic_data;
    logic [SEL_W-1:0]  select;
    logic              sample_valid = 1'b0;
    logic              start = 1'b0;
    logic              circular = 1'b0;
    logic [31:0]       start_address = '0;
    logic [31:0]       ch_stride = '0;
    logic [CNT_W-1:0]  number_samples = '0;
    logic              half_way_ack;
    logic              end_ack = 1'b0;
    logic              half_way_latch, end_latch, overrun, FINISHED, busy;

    logic              hw_ack_drv = 1'b0;
    logic              hw_ack_race = 1'b0;
    logic [15:0]       tag = 16'h0;

    int n_checks = 0, n_fail = 0;
    int acc_count = 0, stall_seen = 0, stall_done = 0, stall_at = 0, stall_len = 0;
    int race_at = 0;
    bit stall_en = 1'b0, race_en = 1'b0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] m_base, m_stride;
    int          m_n, m_idx;
    bit          m_circ;

    mic_dma_ring #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .SEL_LAT(SEL_LAT), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .AM_ADDR        (AM_ADDR),
        .AM_BURSTCOUNT  (AM_BURSTCOUNT),
        .AM_WRITE       (AM_WRITE),
        .AM_WRITEDATA   (AM_WRITEDATA),
        .AM_BYTEENABLE  (AM_BYTEENABLE),
        .AM_WAITREQUEST (AM_WAITREQUEST),
        .mic_data       (mic_data),
        .select         (select),
        .sample_valid   (sample_valid),
        .start          (start),
        .circular       (circular),
        .start_address  (start_address),
        .ch_stride      (ch_stride),
        .number_samples (number_samples),
        .half_way_ack   (half_way_ack),
        .end_ack        (end_ack),
        .half_way_latch (half_way_latch),
        .end_latch      (end_latch),
        .overrun        (overrun),
        .FINISHED       (FINISHED),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    assign mic_data     = {tag, 13'h0, select};
    assign half_way_ack = hw_ack_drv | hw_ack_race;

    // Slave model: optional stall window on one chosen write, plus an ack
    // aimed at the exact acceptance cycle of one chosen write.
    always @(posedge CLK) begin
        #1;
        if (AM_WRITE && stall_en && acc_count == stall_at && stall_done < stall_len) begin
            AM_WAITREQUEST = 1'b1;
            stall_done++;
        end else begin
            AM_WAITREQUEST = 1'b0;
        end
        hw_ack_race = race_en && AM_WRITE && !AM_WAITREQUEST && (acc_count == race_at);
    end

    always @(negedge CLK) begin
        if (!RESET && AM_WRITE === 1'b1) begin
            n_checks++;
            if (exp_addr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", AM_ADDR, AM_WRITEDATA);
                if (!AM_WAITREQUEST) acc_count++;
            end else begin
                if (AM_ADDR !== exp_addr_q[0] || AM_WRITEDATA !== exp_data_q[0]) begin
                    n_fail++;
                    $display("FAIL write_%0d: got addr=%h data=%h, required addr=%h data=%h",
                             acc_count, AM_ADDR, AM_WRITEDATA, exp_addr_q[0], exp_data_q[0]);
                end
                if (AM_WAITREQUEST) stall_seen++;
                else begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_data_q.pop_front());
                    acc_count++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [31:0] stride, input int n, input bit circ);
        start_address  = base;
        ch_stride      = stride;
        number_samples = CNT_W'(n);
        circular       = circ;
        m_base = base; m_stride = stride; m_n = n; m_circ = circ; m_idx = 0;
        start = 1'b1;
        tick(2);
    endtask

    task automatic send_frame(input bit expect_write);
        if (expect_write) begin
            tag = tag + 16'h1111;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                exp_addr_q.push_back(m_base + 32'(ch) * m_stride + 32'(m_idx) * 32'd4);
                exp_data_q.push_back({tag, 13'h0, 3'(ch)});
            end
            m_idx++;
            if (m_circ && m_idx == m_n) m_idx = 0;
        end
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (exp_addr_q.size() != 0 && cyc < 400) begin
            tick(1);
            cyc++;
        end
        n_checks++;
        if (exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_addr_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        tick(2);
    endtask

    task automatic clear_latches();
        hw_ack_drv = 1'b1; end_ack = 1'b1;
        tick(1);
        hw_ack_drv = 1'b0; end_ack = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(3);
        @(negedge CLK);
        n_checks++;
        if ({AM_WRITE, AM_ADDR, AM_WRITEDATA, select} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got write=%b addr=%h data=%h sel=%0d, required all 0", AM_WRITE, AM_ADDR, AM_WRITEDATA, select);
        end
        n_checks++;
        if ({half_way_latch, end_latch, overrun, FINISHED, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b, required 00000", {half_way_latch, end_latch, overrun, FINISHED, busy});
        end
        n_checks++;
        if (AM_BURSTCOUNT !== 3'd1 || AM_BYTEENABLE !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_ties: got burst=%0d be=%h, required 1 f", AM_BURSTCOUNT, AM_BYTEENABLE);
        end
        RESET = 1'b0;
        tick(1);
    endtask

    task automatic test_linear();
        int acc0 = acc_count;
        start_run(32'h1000, 32'h100, 4, 1'b0);
        for (int f = 0; f < 4; f++) begin
            send_frame(1'b1);
            wait_drain("linear");
        end
        n_checks++;
        if (acc_count - acc0 != 20) begin
            n_fail++;
            $display("FAIL linear_count: got %0d writes, required 20", acc_count - acc0);
        end
        n_checks++;
        if ({FINISHED, busy, end_latch, half_way_latch, overrun} !== 5'b10110) begin
            n_fail++;
            $display("FAIL linear_status: got fin/busy/end/half/ovr=%b, required 10110", {FINISHED, busy, end_latch, half_way_latch, overrun});
        end
        clear_latches();
        n_checks++;
        if ({end_latch, half_way_latch} !== 2'b00) begin
            n_fail++;
            $display("FAIL linear_ack: got end/half=%b, required 00", {end_latch, half_way_latch});
        end
        start = 1'b0;
        tick(2);
        n_checks++;
        if ({FINISHED, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL linear_idle: got fin/busy=%b, required 00", {FINISHED, busy});
        end
    endtask

    task automatic test_stall();
        stall_at = acc_count + 1; stall_len = 3; stall_done = 0; stall_seen = 0; stall_en = 1'b1;
        start_run(32'h2000, 32'h40, 1, 1'b0);
        send_frame(1'b1);
        wait_drain("stall");
        stall_en = 1'b0;
        n_checks++;
        if (stall_seen != 3) begin
            n_fail++;
            $display("FAIL stall_cycles: got %0d stalled write cycles, required 3", stall_seen);
        end
        n_checks++;
        if (FINISHED !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_finished: got %b, required 1", FINISHED);
        end
        start = 1'b0;
        tick(2);
        clear_latches();
    endtask

    task automatic test_circular();
        start_run(32'h1000, 32'h100, 2, 1'b1);
        send_frame(1'b1);
        wait_drain("circ0");
        n_checks++;
        if ({half_way_latch, end_latch} !== 2'b10) begin
            n_fail++;
            $display("FAIL circ_half: got half/end=%b, required 10", {half_way_latch, end_latch});
        end
        clear_latches();
        send_frame(1'b1);
        wait_drain("circ1");
        n_checks++;
        if ({half_way_latch, end_latch, FINISHED, busy} !== 4'b0101) begin
            n_fail++;
            $display("FAIL circ_wrap: got half/end/fin/busy=%b, required 0101", {half_way_latch, end_latch, FINISHED, busy});
        end
        clear_latches();
        send_frame(1'b1);
        wait_drain("circ2");
        n_checks++;
        if ({half_way_latch, end_latch} !== 2'b10) begin
            n_fail++;
            $display("FAIL circ_half_again: got half/end=%b, required 10", {half_way_latch, end_latch});
        end
        start = 1'b0;
        tick(2);
        n_checks++;
        if ({FINISHED, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL circ_stop: got fin/busy=%b, required 00", {FINISHED, busy});
        end
        clear_latches();
    endtask

    task automatic test_overrun();
        start_run(32'h3000, 32'h10, 2, 1'b0);
        send_frame(1'b1);
        tick(1);
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        wait_drain("ovr0");
        send_frame(1'b1);
        wait_drain("ovr1");
        n_checks++;
        if ({FINISHED, overrun, end_latch} !== 3'b111) begin
            n_fail++;
            $display("FAIL overrun_sticky: got fin/ovr/end=%b, required 111", {FINISHED, overrun, end_latch});
        end
        start = 1'b0;
        tick(2);
        clear_latches();
    endtask

    task automatic test_zero();
        int acc0 = acc_count;
        start_run(32'h4000, 32'h100, 0, 1'b0);
        tick(2);
        n_checks++;
        if ({FINISHED, busy, end_latch, overrun} !== 4'b1010) begin
            n_fail++;
            $display("FAIL zero_fin: got fin/busy/end/ovr=%b, required 1010", {FINISHED, busy, end_latch, overrun});
        end
        n_checks++;
        if (acc_count != acc0) begin
            n_fail++;
            $display("FAIL zero_writes: got %0d writes, required 0", acc_count - acc0);
        end
        start = 1'b0;
        tick(2);
        clear_latches();
    endtask

    task automatic test_ack_race();
        race_at = acc_count + 2 * NUM_CH - 1; race_en = 1'b1;
        start_run(32'h1000, 32'h100, 4, 1'b0);
        for (int f = 0; f < 2; f++) begin
            send_frame(1'b1);
            wait_drain("race");
        end
        race_en = 1'b0;
        n_checks++;
        if ({half_way_latch, end_latch} !== 2'b00) begin
            n_fail++;
            $display("FAIL race_half: got half/end=%b, required 00", {half_way_latch, end_latch});
        end
        for (int f = 0; f < 2; f++) begin
            send_frame(1'b1);
            wait_drain("race");
        end
        n_checks++;
        if ({half_way_latch, end_latch, FINISHED} !== 3'b011) begin
            n_fail++;
            $display("FAIL race_end: got half/end/fin=%b, required 011", {half_way_latch, end_latch, FINISHED});
        end
        start = 1'b0;
        tick(2);
        clear_latches();
    endtask

    task automatic test_abort();
        int acc0 = acc_count;
        int cyc = 0;
        stall_at = acc_count + 2; stall_len = 6; stall_done = 0; stall_en = 1'b1;
        start_run(32'h5000, 32'h20, 4, 1'b0);
        send_frame(1'b1);
        while (stall_done < 1 && cyc < 200) begin
            tick(1);
            cyc++;
        end
        start = 1'b0;
        tick(30);
        stall_en = 1'b0;
        n_checks++;
        if (acc_count - acc0 != 3 || exp_addr_q.size() != NUM_CH - 3) begin
            n_fail++;
            $display("FAIL abort_writes: got %0d writes, required 3", acc_count - acc0);
        end
        n_checks++;
        if ({FINISHED, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle: got fin/busy=%b, required 00", {FINISHED, busy});
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        clear_latches();
    endtask

    task automatic test_reset_mid_write();
        int cyc = 0;
        stall_at = acc_count; stall_len = 1000; stall_done = 0; stall_en = 1'b1;
        start_run(32'h6000, 32'h100, 4, 1'b0);
        send_frame(1'b1);
        while (stall_done < 2 && cyc < 200) begin
            tick(1);
            cyc++;
        end
        n_checks++;
        if (AM_WRITE !== 1'b1 || AM_WAITREQUEST !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got write=%b wait=%b, required 1 1", AM_WRITE, AM_WAITREQUEST);
        end
        RESET = 1'b1;
        tick(1);
        @(negedge CLK);
        n_checks++;
        if ({AM_WRITE, AM_ADDR, AM_WRITEDATA, select} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_bus: got write=%b addr=%h data=%h sel=%0d, required all 0", AM_WRITE, AM_ADDR, AM_WRITEDATA, select);
        end
        n_checks++;
        if ({half_way_latch, end_latch, overrun, FINISHED, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_status: got %b, required 00000", {half_way_latch, end_latch, overrun, FINISHED, busy});
        end
        stall_en = 1'b0;
        start = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        tick(1);
        RESET = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_linear();
        test_stall();
        test_circular();
        test_overrun();
        test_zero();
        test_ack_race();
        test_abort();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
